// File: rtl/invaders_pkg.sv
// Shared constants for the invaders enemy sprite path: address mux, sprite ROM and read scheduler.
package invaders_pkg;

    localparam int N_ENEMY        = 8;
    localparam int ENEMY_ADDR_W   = 12;
    localparam int SPRITE_DATA_W  = 16;
    localparam int SPRITE_ROM_LAT = 1;

    typedef logic [N_ENEMY-1:0] enemy_vec_t;

    function automatic logic onehot0(input enemy_vec_t v);
        return (v & (v - enemy_vec_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/enemy_rd_sched_if.sv
// Requester / ROM side signal bundle of the enemy read scheduler.
interface enemy_rd_sched_if
    import invaders_pkg::*;
#(
    parameter int N_REQ  = N_ENEMY,
    parameter int DATA_W = SPRITE_DATA_W
);

    logic              en;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [N_REQ-1:0]  rden;
    logic [DATA_W-1:0] q_in;
    logic [DATA_W-1:0] data_out;
    logic [N_REQ-1:0]  data_valid;
    logic              busy;

    modport master (
        output en, req, q_in,
        input  gnt, rden, data_out, data_valid, busy
    );

    modport slave (
        input  en, req, q_in,
        output gnt, rden, data_out, data_valid, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible input at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic             found_c;
    logic [PTR_W-1:0] idx_c;

    // advance_i low suppresses the decision entirely, leaving the pointer where it is.
    always_comb begin
        grant_o = '0;
        ptr_o   = ptr_i;
        found_c = 1'b0;
        idx_c   = '0;
        for (int k = 0; k < N; k++) begin
            idx_c = PTR_W'((int'(ptr_i) + k) % N);
            if (advance_i && !found_c && eligible_i[idx_c]) begin
                found_c        = 1'b1;
                grant_o[idx_c] = 1'b1;
                ptr_o          = (int'(idx_c) == N - 1) ? '0 : idx_c + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/enemy_rd_sched.sv
// Round-robin scheduler sharing the enemy sprite-ROM address path between 8 renderers;
// tracks each read through mux + ROM latency and returns data with a one-hot tag.
module enemy_rd_sched
    import invaders_pkg::*;
#(
    parameter int N_REQ   = N_ENEMY,
    parameter int DATA_W  = SPRITE_DATA_W,
    parameter int ROM_LAT = SPRITE_ROM_LAT
) (
    input logic             clk,
    input logic             rst_n,
    enemy_rd_sched_if.slave bus
);

    localparam int TAG_D = 2 + ROM_LAT;
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  free_req;
    logic [N_REQ-1:0]  gnt_d, gnt_q;
    logic [N_REQ-1:0]  outst_d, outst_q;
    logic [N_REQ-1:0]  tag_q [TAG_D];
    logic [N_REQ-1:0]  tag_any_d;
    logic [DATA_W-1:0] data_q;
    logic              busy_d, busy_q;

    assign free_req = bus.req & ~outst_q;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .eligible_i (free_req),
        .ptr_i      (ptr_q),
        .advance_i  (bus.en),
        .grant_o    (gnt_d),
        .ptr_o      (ptr_d)
    );

    // A slot frees at the end of its data_valid cycle, so re-grant can only land two cycles later.
    assign outst_d = (outst_q & ~tag_q[TAG_D-1]) | gnt_d;

    always_comb begin
        tag_any_d = gnt_q;
        for (int k = 0; k < TAG_D - 1; k++) begin
            tag_any_d = tag_any_d | tag_q[k];
        end
    end

    assign busy_d = |tag_any_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            gnt_q   <= '0;
            outst_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            for (int k = 0; k < TAG_D; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            outst_q  <= outst_d;
            busy_q   <= busy_d;
            tag_q[0] <= gnt_q;
            for (int k = 1; k < TAG_D; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            // tag_q[ROM_LAT] lines up with the cycle in which q_in carries that requester's word.
            if (|tag_q[ROM_LAT]) begin
                data_q <= bus.q_in;
            end
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rden       = gnt_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = tag_q[TAG_D-1];
    assign bus.busy       = busy_q;

    assert property (@(posedge clk) disable iff (!rst_n)
        onehot0(gnt_q) && onehot0(tag_q[TAG_D-1]));

endmodule

// File: tb/tb_enemy_rd_sched.sv
// Scoreboard bench for enemy_rd_sched with a behavioural address-mux + sprite-ROM model.
module tb_enemy_rd_sched;
    import invaders_pkg::*;

    localparam int ROM_LAT = SPRITE_ROM_LAT;
    localparam int OUT_LAT = 2 + ROM_LAT;

    typedef struct {
        int                       cyc;
        enemy_vec_t               vec;
        logic [SPRITE_DATA_W-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enemy_rd_sched_if #(.N_REQ(N_ENEMY), .DATA_W(SPRITE_DATA_W)) bus ();

    enemy_rd_sched #(
        .N_REQ   (N_ENEMY),
        .DATA_W  (SPRITE_DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         rnd_mode = 1'b0;
    exp_t       exp_g[$];
    exp_t       exp_d[$];
    exp_t       mon_e;
    enemy_vec_t req_at_edge = '0;

    function automatic int idx_of(input enemy_vec_t v);
        int r = 0;
        for (int i = 0; i < N_ENEMY; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [ENEMY_ADDR_W-1:0] addr_of(input int i);
        return ENEMY_ADDR_W'(195 + 273 * i);
    endfunction

    function automatic logic [SPRITE_DATA_W-1:0] rom_f(input logic [ENEMY_ADDR_W-1:0] a);
        return {a[3:0], a} ^ 16'h5A3C;
    endfunction

    function automatic exp_t mk(input int c, input enemy_vec_t v);
        exp_t e;
        e.cyc  = c;
        e.vec  = v;
        e.data = rom_f(addr_of(idx_of(v)));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int c, input enemy_vec_t v);
        exp_g.push_back(mk(c, v));
        exp_d.push_back(mk(c + OUT_LAT, v));
    endtask

    // Address mux captures on rden, ROM adds ROM_LAT register stages.
    logic [ENEMY_ADDR_W-1:0]  addr_q = '0;
    logic [SPRITE_DATA_W-1:0] rom_pipe [ROM_LAT];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        req_at_edge <= bus.req;
        if (bus.rden != '0) addr_q <= addr_of(idx_of(bus.rden));
        rom_pipe[0] <= rom_f(addr_q);
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end

    assign bus.q_in = rom_pipe[ROM_LAT-1];

    always @(negedge clk) begin
        if (rst_n) begin
            check("rden_eq_gnt", 32'(bus.rden), 32'(bus.gnt));
            check("gnt_onehot0", 32'(onehot0(bus.gnt)), 32'd1);
            check("dv_onehot0", 32'(onehot0(bus.data_valid)), 32'd1);
            check("gnt_has_req", 32'(bus.gnt & ~req_at_edge), 32'd0);
            if (bus.gnt != '0) begin
                if (rnd_mode) begin
                    exp_d.push_back(mk(cyc + OUT_LAT, bus.gnt));
                end else if (exp_g.size() == 0) begin
                    check("unexpected_gnt", 32'(bus.gnt), 32'd0);
                end else begin
                    mon_e = exp_g.pop_front();
                    check("gnt_value", 32'(bus.gnt), 32'(mon_e.vec));
                    check("gnt_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
            if (bus.data_valid != '0) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_dv", 32'(bus.data_valid), 32'd0);
                end else begin
                    mon_e = exp_d.pop_front();
                    check("dv_value", 32'(bus.data_valid), 32'(mon_e.vec));
                    check("dv_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("dv_data", 32'(bus.data_out), 32'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    initial begin
        int c;
        bus.req = '0;
        bus.en  = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_rden", 32'(bus.rden), 32'd0);
        check("rst_dv", 32'(bus.data_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        #2 rst_n = 1'b1;

        // All requesters held: 01..80 then wrap, no bubbles.
        repeat (2) @(negedge clk);
        c = cyc;
        bus.req = 8'hFF;
        for (int k = 0; k < 12; k++) expect_grant(c + 1 + k, enemy_vec_t'(1) << (k % 8));
        repeat (12) @(negedge clk);
        bus.req = '0;
        repeat (8) @(negedge clk);

        // Reset mid-burst: ptr is 4, two reads get dropped.
        c = cyc;
        bus.req = 8'hFF;
        expect_grant(c + 1, 8'h10);
        expect_grant(c + 2, 8'h20);
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        check("midrst_rden", 32'(bus.rden), 32'd0);
        check("midrst_dv", 32'(bus.data_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_data", 32'(bus.data_out), 32'd0);
        exp_g.delete();
        exp_d.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        c = cyc;
        expect_grant(c + 1, 8'h01);
        @(negedge clk);
        bus.req = '0;
        repeat (8) @(negedge clk);

        // Move ptr to 6, then wrap: 40, 01, 40.
        c = cyc;
        bus.req = 8'h20;
        expect_grant(c + 1, 8'h20);
        @(negedge clk);
        bus.req = '0;
        repeat (6) @(negedge clk);
        c = cyc;
        bus.req = 8'h41;
        expect_grant(c + 1, 8'h40);
        expect_grant(c + 2, 8'h01);
        expect_grant(c + 3 + OUT_LAT, 8'h40);
        repeat (3 + OUT_LAT) @(negedge clk);
        bus.req = '0;
        repeat (8) @(negedge clk);

        // en drop with two reads in flight (ptr 7).
        c = cyc;
        bus.req = 8'h81;
        expect_grant(c + 1, 8'h80);
        expect_grant(c + 2, 8'h01);
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        repeat (OUT_LAT) @(negedge clk);
        check("busy_last_dv", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_after", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        check("data_hold", 32'(bus.data_out), 32'(rom_f(addr_of(0))));
        c = cyc;
        bus.en = 1'b1;
        expect_grant(c + 1, 8'h80);
        expect_grant(c + 2, 8'h01);
        repeat (2) @(negedge clk);
        bus.req = '0;
        repeat (8) @(negedge clk);

        // Single requester held: re-grant once its slot frees.
        c = cyc;
        bus.req = 8'h04;
        expect_grant(c + 1, 8'h04);
        expect_grant(c + 3 + OUT_LAT, 8'h04);
        repeat (3 + OUT_LAT) @(negedge clk);
        bus.req = '0;
        repeat (8) @(negedge clk);

        // Random requests: invariants plus tag latency and data tracking.
        rnd_mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            bus.req = enemy_vec_t'($urandom);
            bus.en  = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.req = '0;
        bus.en  = 1'b1;
        repeat (10) @(negedge clk);
        rnd_mode = 1'b0;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("exp_g_drained", 32'(exp_g.size()), 32'd0);
        check("exp_d_drained", 32'(exp_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
